// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, muldiv FSM states and the iterative-op classifier; ALU_DIV_EN enables DIV/DIVU as iterative ops
package alu_pkg;
  typedef enum logic [4:0] {
    C_ADD_U = 5'd0,
    C_SUB_U = 5'd1,
    C_AND   = 5'd2,
    C_OR    = 5'd3,
    C_XOR   = 5'd4,
    C_SLL   = 5'd5,
    C_SRL   = 5'd6,
    C_SRA   = 5'd7,
    C_SLT   = 5'd8,
    C_SLTU  = 5'd9,
    C_MFHI  = 5'd10,
    C_MFLO  = 5'd11,
    C_JR    = 5'd12,
    C_BEQ   = 5'd13,
    C_BNE   = 5'd14,
    C_BLEZ  = 5'd15,
    C_BGTZ  = 5'd16,
    C_BLTZ  = 5'd17,
    C_BGEZ  = 5'd18,
    C_MULT  = 5'd19,
    C_MUL_U = 5'd20,
    C_DIV   = 5'd21,
    C_DIVU  = 5'd22
  } alu_sel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} muldiv_state_t;
  function automatic logic is_iter(alu_sel_t s);
`ifdef ALU_DIV_EN
    return s == C_MULT || s == C_MUL_U || s == C_DIV || s == C_DIVU;
`else
    return s == C_MULT || s == C_MUL_U;
`endif
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: WIDTH-cycle shift-add multiplier (restoring divider when ALU_DIV_EN) producing {hi,lo}
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  alu_sel_t         i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  muldiv_state_t r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_mcand;
  logic r_neg_q;
  logic w_sgn, w_last;
  logic [WIDTH-1:0] w_ma, w_mb, w_nhi, w_nlo;
  logic [WIDTH:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
`ifdef ALU_DIV_EN
  logic r_div, r_neg_r, r_dz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH:0] w_sh, w_diff;
  assign w_sgn  = i_op == C_MULT || i_op == C_DIV;
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_mcand};
`else
  assign w_sgn = i_op == C_MULT;
`endif
  assign w_ma   = (w_sgn & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mb   = (w_sgn & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_sum  = {1'b0, r_hi} + {1'b0, {WIDTH{r_lo[0]}} & r_mcand};
  assign w_prod = {w_sum, r_lo[WIDTH-1:1]};
  assign w_last = r_state == RUN && r_cnt == SHAMT_W'(WIDTH - 1);
  assign o_busy = r_state == RUN;
  assign o_done = w_last;
  // next {hi,lo} step plus sign/zero-divide fixup of the final value
  always_comb begin
`ifdef ALU_DIV_EN
    w_nhi = r_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_prod[2*WIDTH-1:WIDTH];
    w_nlo = r_div ? {r_lo[WIDTH-2:0], ~w_diff[WIDTH]} : w_prod[WIDTH-1:0];
    {o_hi, o_lo} = r_neg_q ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    if (r_div) begin
      o_lo = r_dz ? '1 : r_neg_q ? -w_nlo : w_nlo;
      o_hi = r_dz ? r_a : r_neg_r ? -w_nhi : w_nhi;
    end
`else
    w_nhi = w_prod[2*WIDTH-1:WIDTH];
    w_nlo = w_prod[WIDTH-1:0];
    {o_hi, o_lo} = r_neg_q ? -w_prod : w_prod;
`endif
  end
  // IDLE/DONE load magnitudes on start; RUN performs one iteration per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_neg_q <= 1'b0;
`ifdef ALU_DIV_EN
      r_div   <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
`endif
    end else if (r_state == RUN) begin
      r_state <= w_last ? DONE : RUN;
      r_cnt   <= r_cnt + SHAMT_W'(1);
      r_hi    <= w_nhi;
      r_lo    <= w_nlo;
    end else begin
      r_state <= i_start ? RUN : IDLE;
      if (i_start) begin
        r_cnt   <= '0;
        r_hi    <= '0;
        r_lo    <= w_ma;
        r_mcand <= w_mb;
        r_neg_q <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
`ifdef ALU_DIV_EN
        r_div   <= i_op == C_DIV || i_op == C_DIVU;
        r_neg_r <= w_sgn & i_a[WIDTH-1];
        r_dz    <= i_b == '0;
        r_a     <= i_a;
`endif
      end
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS execute ALU with HI/LO and iterative MULT/MULTU; ALU_DIV_EN adds DIV/DIVU
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_sel_t           sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               branch_taken,
  output logic               busy
);
  logic [WIDTH-1:0] r_hi, r_lo, w_res, w_md_hi, w_md_lo;
  logic w_acc, w_iter, w_br, w_done;
  assign in_ready = ~busy;
  assign w_acc    = in_valid & in_ready;
  assign w_iter   = is_iter(sel);
  alu_iter_muldiv #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_md (
    .clk(clk), .rst(rst), .i_start(w_acc & w_iter), .i_op(sel), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(w_done), .o_hi(w_md_hi), .o_lo(w_md_lo)
  );
  // single-cycle result and branch condition; iterative and undefined codes yield zero
  always_comb begin
    w_res = '0;
    w_br  = 1'b0;
    case (sel)
      C_ADD_U: w_res = a + b;
      C_SUB_U: w_res = a - b;
      C_AND:   w_res = a & b;
      C_OR:    w_res = a | b;
      C_XOR:   w_res = a ^ b;
      C_SLL:   w_res = b << shamt;
      C_SRL:   w_res = b >> shamt;
      C_SRA:   w_res = $signed(b) >>> shamt;
      C_SLT:   w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      C_SLTU:  w_res = {{(WIDTH-1){1'b0}}, a < b};
      C_MFHI:  w_res = r_hi;
      C_MFLO:  w_res = r_lo;
      C_JR:    w_res = a;
      C_BEQ:   w_br = a == b;
      C_BNE:   w_br = a != b;
      C_BLEZ:  w_br = a[WIDTH-1] | (a == '0);
      C_BGTZ:  w_br = ~a[WIDTH-1] & (a != '0);
      C_BLTZ:  w_br = a[WIDTH-1];
      C_BGEZ:  w_br = ~a[WIDTH-1];
      default: ;
    endcase
  end
  // output registers; HI/LO only change when an iterative op completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi         <= '0;
      r_lo         <= '0;
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else if (w_done) begin
      r_hi         <= w_md_hi;
      r_lo         <= w_md_lo;
      out_valid    <= 1'b1;
      result       <= '0;
      branch_taken <= 1'b0;
    end else begin
      out_valid    <= w_acc & ~w_iter;
      result       <= (w_acc & ~w_iter) ? w_res : result;
      branch_taken <= (w_acc & ~w_iter) ? w_br : branch_taken;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32; DIV vectors follow ALU_DIV_EN
module tb_alu_mc;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  alu_sel_t sel = C_ADD_U;
  logic [31:0] a = '0, b = '0;
  logic [4:0] shamt = '0;
  logic in_ready, out_valid, branch_taken, busy;
  logic [31:0] result;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .result(result),
    .branch_taken(branch_taken), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic op1(input string tag, input alu_sel_t s, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [4:0] sh, input logic [31:0] er, input logic eb);
    sel = s; a = aa; b = bb; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".branch"}, 32'(branch_taken), 32'(eb));
  endtask

  task automatic mdrun(input string tag, input alu_sel_t s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el);
    int n, low;
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    low = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd33);
    chk({tag, ".ready_low"}, 32'(low), 32'd32);
    chk({tag, ".done_result"}, result, 32'd0);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    op1({tag, ".hi"}, C_MFHI, 32'd0, 32'd0, 5'd0, eh, 1'b0);
    op1({tag, ".lo"}, C_MFLO, 32'd0, 32'd0, 5'd0, el, 1'b0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.branch", 32'(branch_taken), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    op1("mfhi0", C_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    op1("add", C_ADD_U, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b0);
    op1("sub", C_SUB_U, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0);
    op1("and", C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0);
    op1("or", C_OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0);
    op1("xor", C_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0);
    op1("sll", C_SLL, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0);
    op1("srl", C_SRL, 32'd0, 32'h80000000, 5'd4, 32'h08000000, 1'b0);
    op1("sra", C_SRA, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
    op1("slt", C_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    op1("slt0", C_SLT, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b0);
    op1("sltu", C_SLTU, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1, 1'b0);
    op1("sltu0", C_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b0);
    op1("jr", C_JR, 32'h12345678, 32'd0, 5'd0, 32'h12345678, 1'b0);
    op1("beq", C_BEQ, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1);
    op1("bne", C_BNE, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);
    op1("bne1", C_BNE, 32'd5, 32'd6, 5'd0, 32'd0, 1'b1);
    op1("blez", C_BLEZ, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
    op1("blez1", C_BLEZ, 32'd1, 32'd0, 5'd0, 32'd0, 1'b0);
    op1("bgtz", C_BGTZ, 32'h80000000, 32'd0, 5'd0, 32'd0, 1'b0);
    op1("bgtz1", C_BGTZ, 32'd1, 32'd0, 5'd0, 32'd0, 1'b1);
    op1("bltz", C_BLTZ, 32'h80000000, 32'd0, 5'd0, 32'd0, 1'b1);
    op1("bgez", C_BGEZ, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
    op1("bgez1", C_BGEZ, 32'hFFFFFFFF, 32'd0, 5'd0, 32'd0, 1'b0);
    op1("jr2", C_JR, 32'hDEADBEEF, 32'd0, 5'd0, 32'hDEADBEEF, 1'b0);
    op1("undef", alu_sel_t'(5'd27), 32'd1, 32'd2, 5'd3, 32'd0, 1'b0);
`ifndef ALU_DIV_EN
    op1("jr3", C_JR, 32'h0BADF00D, 32'd0, 5'd0, 32'h0BADF00D, 1'b0);
    op1("div_off", C_DIV, 32'd7, 32'd2, 5'd0, 32'd0, 1'b0);
    op1("divu_off", C_DIVU, 32'd7, 32'd0, 5'd0, 32'd0, 1'b0);
`endif
    mdrun("mult", C_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    mdrun("multu", C_MUL_U, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    mdrun("mult_minneg", C_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    mdrun("mult_minsq", C_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    mdrun("multu_big", C_MUL_U, 32'h80000000, 32'd3, 32'h00000001, 32'h80000000);
    sel = C_MULT; a = 32'd7; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("abort.no_valid", 32'(n), 32'd0);
    op1("abort.hi", C_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    op1("abort.lo", C_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    mdrun("mult79", C_MULT, 32'd7, 32'd9, 32'd0, 32'd63);
`ifdef ALU_DIV_EN
    mdrun("div", C_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mdrun("divu0", C_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    mdrun("divu", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    mdrun("div_neg_b", C_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
